rx_capture_ctrl: RTL
====================

RX_CAPTURE_CTRL -- requirements
Module: rx_capture_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning output FIFO depth in 256-bit words (power of 2, min 2).
REQ-002 SHALL have parameter LEN_W, default 16, meaning width of capture length and word counter.
REQ-003 SHALL have port clk  in  1  single clock for all logic.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port s_data  in  256  mapped sample word, 16 x 16-bit samples from the RX mapper output.
REQ-006 SHALL have port s_valid  in  1  s_data valid this cycle; source cannot be stalled.
REQ-007 SHALL have port arm  in  1  single-cycle pulse that arms a capture.
REQ-008 SHALL have port abort  in  1  single-cycle pulse that cancels any activity.
REQ-009 SHALL have port trig_mode  in  1  0 = immediate, 1 = external trigger.
REQ-010 SHALL have port ext_trig  in  1  external trigger level; rising edge is used.
REQ-011 SHALL have port cap_len  in  LEN_W  words per capture, latched on accepted arm.
REQ-012 SHALL have port m_tdata  out  256  AXI-Stream data.
REQ-013 SHALL have ports m_tvalid  out  1, m_tlast  out  1 and m_tready  in  1, forming the AXI-Stream handshake.
REQ-014 SHALL have port busy  out  1  high in ARMED, CAPTURE or DRAIN.
REQ-015 SHALL have port done  out  1  high in DONE.
REQ-016 SHALL have port overflow  out  1  sticky flag for FIFO overrun.
REQ-017 SHALL have port word_cnt  out  LEN_W  words written into the FIFO during the current capture.

Function
REQ-018 SHALL implement states IDLE, ARMED, CAPTURE, DRAIN and DONE.
REQ-019 IDLE or DONE: arm with cap_len != 0 SHALL latch cap_len, clear word_cnt and overflow, and enter ARMED; arm with cap_len == 0 SHALL be ignored.
REQ-020 ARMED: trig_mode = 0 SHALL enter CAPTURE on the next cycle; trig_mode = 1 SHALL enter CAPTURE on the cycle after ext_trig is sampled 0 then 1 on consecutive clocks.
REQ-021 ext_trig edge detection SHALL use a single register; ext_trig high on the arm cycle SHALL NOT count as an edge.
REQ-022 CAPTURE: each cycle with s_valid = 1 SHALL write s_data to the FIFO and increment word_cnt; s_valid = 0 cycles SHALL write nothing.
REQ-023 The write that makes word_cnt == latched length SHALL tag that entry last and move to DRAIN on the next cycle.
REQ-024 DRAIN SHALL enter DONE on the cycle after the FIFO is empty.
REQ-025 A FIFO read SHALL occur on m_tvalid & m_tready; m_tlast SHALL equal the head entry's last tag.
REQ-026 m_tvalid SHALL be high exactly when the FIFO is non-empty; m_tdata and m_tlast SHALL hold stable while m_tvalid & !m_tready.
REQ-027 Latency: a word written in cycle N SHALL be presentable on m_tdata in cycle N+1.
REQ-028 A write and a read in the same cycle while the FIFO is full SHALL both succeed, with no overflow.
REQ-029 A write attempt with the FIFO full and no read in the same cycle SHALL drop the word, set overflow, flush the FIFO, and enter DONE; no m_tlast is issued for that capture.
REQ-030 arm in ARMED, CAPTURE or DRAIN SHALL be ignored.
REQ-031 abort in any state SHALL flush the FIFO and enter IDLE on the next cycle; overflow and word_cnt SHALL be retained.
REQ-032 When abort and arm occur in the same cycle, abort SHALL take precedence.
REQ-033 word_cnt SHALL saturate at the latched length and never wrap.

Reset
REQ-034 rst SHALL force state IDLE, flush the FIFO, and clear the trigger edge register.
REQ-035 rst SHALL drive m_tvalid, m_tlast, busy, done, overflow and word_cnt to 0; m_tdata is don't-care while m_tvalid = 0.
REQ-036 rst asserted mid-capture SHALL take effect on the next edge, with no further stream output.

Verification
REQ-037 Immediate capture: trig_mode = 0, cap_len = 8, s_valid continuous, m_tready = 1 -> 8 beats equal to the input words, m_tlast on beat 8, done after drain, word_cnt = 8.
REQ-038 External trigger: trig_mode = 1, ext_trig held high at arm then pulsed 0 -> 1 after 20 cycles -> no capture before the edge, first beat = first valid word after the edge.
REQ-039 Backpressure: cap_len = 6, m_tready low for 3 cycles mid-stream -> no data loss, stable tdata during stall, overflow = 0.
REQ-040 Overrun: DEPTH = 4, m_tready = 0, s_valid continuous, cap_len = 10 -> 5th write sets overflow, state DONE, m_tvalid = 0, word_cnt = 4.
REQ-041 Abort/arm collision: abort and arm together during CAPTURE -> IDLE next cycle, FIFO empty, busy = 0.
REQ-042 Zero length and reset: arm with cap_len = 0 -> stays IDLE; rst during CAPTURE -> all outputs 0 on the next cycle.

Source files
------------

// File: rtl/rx_capture_ctrl.sv
// rx_capture_ctrl: arms on a pulse, waits for an immediate or external
// trigger, captures a fixed number of 256-bit sample words into a small
// FIFO and streams them out over AXI-Stream with tlast on the final word.
module rx_capture_ctrl #(
  parameter int DEPTH = 4,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [255:0]     s_data,
  input  logic             s_valid,
  input  logic             arm,
  input  logic             abort,
  input  logic             trig_mode,
  input  logic             ext_trig,
  input  logic [LEN_W-1:0] cap_len,
  output logic [255:0]     m_tdata,
  output logic             m_tvalid,
  output logic             m_tlast,
  input  logic             m_tready,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [LEN_W-1:0] word_cnt
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_CAPTURE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             trig_q;

  logic [255:0]     mem_data_q [DEPTH];
  logic [DEPTH-1:0] mem_last_q;

  logic fifo_empty, fifo_full, rd_en, wr_en, wr_last, flush;

  // Counter increment that holds at the limit instead of wrapping.
  function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] cnt,
                                               input logic [LEN_W-1:0] lim);
    sat_inc = (cnt >= lim) ? lim : cnt + LEN_W'(1);
  endfunction

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_en      = !fifo_empty && m_tready;

  // Next-state, capture bookkeeping and FIFO pointer control.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    wr_en    = 1'b0;
    wr_last  = 1'b0;
    flush    = 1'b0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, rd_en};

    case (state_q)
      S_IDLE, S_DONE: begin
        if (arm && (cap_len != '0)) begin
          len_d   = cap_len;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = S_ARMED;
        end
      end
      S_ARMED: begin
        // trig_q holds last cycle's ext_trig, so a level already high at
        // arm time never looks like an edge here.
        if (!trig_mode || (ext_trig && !trig_q)) begin
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (s_valid) begin
          if (fifo_full && !rd_en) begin
            // Overrun: the capture is unusable, discard everything.
            ovf_d   = 1'b1;
            flush   = 1'b1;
            state_d = S_DONE;
          end else begin
            wr_en = 1'b1;
            cnt_d = sat_inc(cnt_q, len_q);
            if (cnt_q + LEN_W'(1) == len_q) begin
              wr_last = 1'b1;
              state_d = S_DRAIN;
            end
          end
        end
      end
      S_DRAIN: begin
        if (fifo_empty) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides everything, including a simultaneous arm, but keeps
    // the status of the capture it cancelled.
    if (abort) begin
      state_d = S_IDLE;
      len_d   = len_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      wr_en   = 1'b0;
      wr_last = 1'b0;
      flush   = 1'b1;
    end

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    end
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  // Control registers; reset returns to IDLE with an empty FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      trig_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      trig_q   <= ext_trig;
    end
  end

  // FIFO storage: data plus last tag, no reset needed behind the pointers.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_data_q[wr_ptr_q[AW-1:0]] <= s_data;
      mem_last_q[wr_ptr_q[AW-1:0]] <= wr_last;
    end
  end

  assign m_tvalid = !fifo_empty;
  assign m_tdata  = mem_data_q[rd_ptr_q[AW-1:0]];
  assign m_tlast  = !fifo_empty && mem_last_q[rd_ptr_q[AW-1:0]];
  assign busy     = (state_q == S_ARMED) || (state_q == S_CAPTURE) ||
                    (state_q == S_DRAIN);
  assign done     = (state_q == S_DONE);
  assign overflow = ovf_q;
  assign word_cnt = cnt_q;

endmodule
